// File: rtl/pipeline_ingress_pkg.sv
// Shared types and constants for the dual-lane ingress buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ingress_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 2;

    typedef logic [DATA_W-1:0] lane_data_t;

endpackage : pipeline_ingress_pkg

// File: rtl/ingress_lane_fifo.sv
// Single-lane FIFO with flush, stall-gated pop and optional zero-latency bypass.
// Latency: 1 cycle push-to-present (0 cycles via cut-through when INGRESS_BYPASS_EN is defined).
// Backpressure: src_ready drops when full or flushing; a pop while full reopens it next cycle.
//
// Ports: clk/reset (async active-high); src_data/src_valid/src_ready producer side;
//        flush/stall from the pipeline; pipe_data/pipe_valid to the pipeline; occupancy count.
// Build option: INGRESS_BYPASS_EN enables cut-through when the lane is empty.
module ingress_lane_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              flush,
    input  logic              stall,
    output logic [DATA_W-1:0] pipe_data,
    output logic              pipe_valid,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              full, empty, push, pop, bypass;

    assign full  = (occ_q == CNT_W'(DEPTH));
    assign empty = (occ_q == '0);

    // Ready depends only on registered state and flush, never on src_valid.
    assign src_ready = !full && !flush;

`ifdef INGRESS_BYPASS_EN
    // Cut-through only when nothing is queued, so ordering is preserved.
    // Gated by reset so outputs stay quiet while reset is held.
    assign bypass = empty && !stall && !flush && !reset && src_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pipe_valid = bypass || (!empty && !stall && !flush);
    assign pipe_data  = bypass ? src_data : (empty ? '0 : mem_q[rd_ptr_q]);
    assign occupancy  = occ_q;

    // A bypassed word is consumed directly and never written.
    assign push = src_valid && src_ready && !bypass;
    assign pop  = pipe_valid && !bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= src_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        occ_q <= CNT_W'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && full));

endmodule : ingress_lane_fifo

// File: rtl/pipeline_ingress_buffer.sv
// Dual-lane ingress buffer feeding the two-pipeline wrapper; lanes are independent.
// Latency: 1 cycle per lane (0 with INGRESS_BYPASS_EN on an empty lane).
// Backpressure: per-lane src_ready drops when that lane is full or flushing.
//
// Ports: clk, reset (async active-high); src_data_n/src_valid_n/src_ready_n per lane;
//        flush_n/stall_n per pipeline; pipe_data_n, pipe_valid[1:0] (bit0 = lane 1);
//        occupancy_n entry counts.
// Build option: INGRESS_BYPASS_EN (handled inside ingress_lane_fifo).
module pipeline_ingress_buffer
    import pipeline_ingress_pkg::*;
#(
    parameter  int DATA_W = pipeline_ingress_pkg::DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    src_data_1,
    input  logic                 src_valid_1,
    output logic                 src_ready_1,
    input  logic [DATA_W-1:0]    src_data_2,
    input  logic                 src_valid_2,
    output logic                 src_ready_2,
    input  logic                 flush_1,
    input  logic                 flush_2,
    input  logic                 stall_1,
    input  logic                 stall_2,
    output logic [DATA_W-1:0]    pipe_data_1,
    output logic [DATA_W-1:0]    pipe_data_2,
    output logic [NUM_LANES-1:0] pipe_valid,
    output logic [CNT_W-1:0]     occupancy_1,
    output logic [CNT_W-1:0]     occupancy_2
);

    ingress_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_1 (
        .clk        (clk),
        .reset      (reset),
        .src_data   (src_data_1),
        .src_valid  (src_valid_1),
        .src_ready  (src_ready_1),
        .flush      (flush_1),
        .stall      (stall_1),
        .pipe_data  (pipe_data_1),
        .pipe_valid (pipe_valid[0]),
        .occupancy  (occupancy_1)
    );

    ingress_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane_2 (
        .clk        (clk),
        .reset      (reset),
        .src_data   (src_data_2),
        .src_valid  (src_valid_2),
        .src_ready  (src_ready_2),
        .flush      (flush_2),
        .stall      (stall_2),
        .pipe_data  (pipe_data_2),
        .pipe_valid (pipe_valid[1]),
        .occupancy  (occupancy_2)
    );

endmodule : pipeline_ingress_buffer

// File: tb/tb_pipeline_ingress_buffer.sv
// Directed bench for pipeline_ingress_buffer (DEPTH=4, DATA_W=32).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expectations follow INGRESS_BYPASS_EN when that macro is defined.
module tb_pipeline_ingress_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src_data_1, src_data_2;
    logic        src_valid_1, src_valid_2;
    logic        src_ready_1, src_ready_2;
    logic        flush_1, flush_2, stall_1, stall_2;
    logic [31:0] pipe_data_1, pipe_data_2;
    logic [1:0]  pipe_valid;
    logic [2:0]  occupancy_1, occupancy_2;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_ingress_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .src_data_1  (src_data_1),
        .src_valid_1 (src_valid_1),
        .src_ready_1 (src_ready_1),
        .src_data_2  (src_data_2),
        .src_valid_2 (src_valid_2),
        .src_ready_2 (src_ready_2),
        .flush_1     (flush_1),
        .flush_2     (flush_2),
        .stall_1     (stall_1),
        .stall_2     (stall_2),
        .pipe_data_1 (pipe_data_1),
        .pipe_data_2 (pipe_data_2),
        .pipe_valid  (pipe_valid),
        .occupancy_1 (occupancy_1),
        .occupancy_2 (occupancy_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; src_valid_1 = 1'b1; src_data_1 = 32'h0; src_valid_2 = 1'b0; src_data_2 = 32'h0;
        flush_1 = 1'b0; flush_2 = 1'b0; stall_1 = 1'b0; stall_2 = 1'b0;
        tick(); tick();
        #1;
        n_checks++; if (pipe_valid !== 2'b00) $display("FAIL rst_pipe_valid got %b want 00", pipe_valid); else n_pass++;
        n_checks++; if ({src_ready_2, src_ready_1} !== 2'b11) $display("FAIL rst_src_ready got %b want 11", {src_ready_2, src_ready_1}); else n_pass++;
        n_checks++; if (occupancy_1 !== 3'd0 || occupancy_2 !== 3'd0) $display("FAIL rst_occ got %0d/%0d want 0/0", occupancy_1, occupancy_2); else n_pass++;
        n_checks++; if (pipe_data_1 !== 32'h0) $display("FAIL rst_pipe_data got %h want 0", pipe_data_1); else n_pass++;
        tick();
        reset = 1'b0; src_data_1 = 32'hA5A5_0001; src_valid_1 = 1'b1;
        #1;
`ifdef INGRESS_BYPASS_EN
        n_checks++; if (pipe_valid[0] !== 1'b1 || pipe_data_1 !== 32'hA5A5_0001) $display("FAIL first_bypass got %b/%h want 1/a5a50001", pipe_valid[0], pipe_data_1); else n_pass++;
`else
        n_checks++; if (pipe_valid[0] !== 1'b0) $display("FAIL first_same_cycle got %b want 0", pipe_valid[0]); else n_pass++;
`endif
        tick();
        src_valid_1 = 1'b0;
        #1;
`ifdef INGRESS_BYPASS_EN
        n_checks++; if (occupancy_1 !== 3'd0 || pipe_valid[0] !== 1'b0) $display("FAIL first_after got occ %0d v %b want 0 0", occupancy_1, pipe_valid[0]); else n_pass++;
`else
        n_checks++; if (pipe_valid[0] !== 1'b1 || pipe_data_1 !== 32'hA5A5_0001) $display("FAIL first_present got %b/%h want 1/a5a50001", pipe_valid[0], pipe_data_1); else n_pass++;
        n_checks++; if (occupancy_1 !== 3'd1) $display("FAIL first_occ got %0d want 1", occupancy_1); else n_pass++;
`endif
        tick();
        #1;
        n_checks++; if (occupancy_1 !== 3'd0 || pipe_valid !== 2'b00) $display("FAIL first_drain got occ %0d v %b want 0 00", occupancy_1, pipe_valid); else n_pass++;
    endtask

    task automatic test_stall_fill();
        stall_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src_data_1 = 32'h10 + 32'(i); src_valid_1 = 1'b1;
            #1;
            n_checks++; if (occupancy_1 !== 3'(i < 4 ? i : 4)) $display("FAIL stall_occ[%0d] got %0d want %0d", i, occupancy_1, (i < 4 ? i : 4)); else n_pass++;
            n_checks++; if (src_ready_1 !== (i < 4)) $display("FAIL stall_ready[%0d] got %b want %b", i, src_ready_1, (i < 4)); else n_pass++;
            n_checks++; if (pipe_valid[0] !== 1'b0) $display("FAIL stall_valid[%0d] got %b want 0", i, pipe_valid[0]); else n_pass++;
            n_checks++; if (pipe_data_1 !== (i == 0 ? 32'h0 : 32'h10)) $display("FAIL stall_head[%0d] got %h want %h", i, pipe_data_1, (i == 0 ? 32'h0 : 32'h10)); else n_pass++;
            tick();
        end
        src_valid_1 = 1'b0; stall_1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (pipe_valid[0] !== 1'b1 || pipe_data_1 !== 32'h10 + 32'(k)) $display("FAIL drain[%0d] got %b/%h want 1/%h", k, pipe_valid[0], pipe_data_1, 32'h10 + 32'(k)); else n_pass++;
            n_checks++; if (src_ready_1 !== (k != 0)) $display("FAIL drain_ready[%0d] got %b want %b", k, src_ready_1, (k != 0)); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (pipe_valid[0] !== 1'b0 || occupancy_1 !== 3'd0 || src_ready_1 !== 1'b1) $display("FAIL drain_end got v %b occ %0d rdy %b want 0 0 1", pipe_valid[0], occupancy_1, src_ready_1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        stall_2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            src_data_2 = 32'h200 + 32'(i); src_valid_2 = 1'b1;
            #1;
`ifdef INGRESS_BYPASS_EN
            n_checks++; if (pipe_valid[1] !== 1'b1 || pipe_data_2 !== 32'h200 + 32'(i) || occupancy_2 !== 3'd0) $display("FAIL b2b[%0d] got %b/%h occ %0d want 1/%h occ 0", i, pipe_valid[1], pipe_data_2, occupancy_2, 32'h200 + 32'(i)); else n_pass++;
`else
            if (i > 0) begin
                n_checks++; if (pipe_valid[1] !== 1'b1 || pipe_data_2 !== 32'h200 + 32'(i - 1) || occupancy_2 !== 3'd1) $display("FAIL b2b[%0d] got %b/%h occ %0d want 1/%h occ 1", i, pipe_valid[1], pipe_data_2, occupancy_2, 32'h200 + 32'(i - 1)); else n_pass++;
            end
`endif
            tick();
        end
        src_valid_2 = 1'b0;
        #1;
`ifndef INGRESS_BYPASS_EN
        n_checks++; if (pipe_valid[1] !== 1'b1 || pipe_data_2 !== 32'h209) $display("FAIL b2b_last got %b/%h want 1/00000209", pipe_valid[1], pipe_data_2); else n_pass++;
        tick();
        #1;
`endif
        n_checks++; if (pipe_valid[1] !== 1'b0 || occupancy_2 !== 3'd0) $display("FAIL b2b_end got v %b occ %0d want 0 0", pipe_valid[1], occupancy_2); else n_pass++;
    endtask

    task automatic test_flush();
        stall_1 = 1'b1; stall_2 = 1'b1;
        src_data_1 = 32'h30; src_valid_1 = 1'b1; src_data_2 = 32'h2AA; src_valid_2 = 1'b1;
        tick();
        src_data_1 = 32'h31; src_valid_2 = 1'b0;
        tick();
        src_data_1 = 32'h32;
        tick();
        src_data_1 = 32'h33; flush_1 = 1'b1;
        #1;
        n_checks++; if (occupancy_1 !== 3'd3 || src_ready_1 !== 1'b0 || pipe_valid[0] !== 1'b0) $display("FAIL flush_cycle got occ %0d rdy %b v %b want 3 0 0", occupancy_1, src_ready_1, pipe_valid[0]); else n_pass++;
        tick();
        flush_1 = 1'b0; src_valid_1 = 1'b0; stall_1 = 1'b0;
        #1;
        n_checks++; if (occupancy_1 !== 3'd0 || pipe_valid[0] !== 1'b0 || pipe_data_1 !== 32'h0) $display("FAIL flush_after got occ %0d v %b d %h want 0 0 0", occupancy_1, pipe_valid[0], pipe_data_1); else n_pass++;
        n_checks++; if (src_ready_1 !== 1'b1) $display("FAIL flush_ready got %b want 1", src_ready_1); else n_pass++;
        n_checks++; if (occupancy_2 !== 3'd1 || pipe_data_2 !== 32'h2AA) $display("FAIL flush_lane2 got occ %0d d %h want 1 000002aa", occupancy_2, pipe_data_2); else n_pass++;
        stall_2 = 1'b0;
        #1;
        n_checks++; if (pipe_valid[1] !== 1'b1) $display("FAIL flush_lane2_v got %b want 1", pipe_valid[1]); else n_pass++;
        tick();
        #1;
        n_checks++; if (occupancy_2 !== 3'd0) $display("FAIL flush_lane2_drain got %0d want 0", occupancy_2); else n_pass++;
    endtask

    task automatic test_async_reset();
        stall_1 = 1'b1;
        src_data_1 = 32'h40; src_valid_1 = 1'b1;
        tick();
        src_data_1 = 32'h41;
        tick();
        src_valid_1 = 1'b0;
        #1;
        n_checks++; if (occupancy_1 !== 3'd2 || pipe_data_1 !== 32'h40) $display("FAIL arst_pre got occ %0d d %h want 2 00000040", occupancy_1, pipe_data_1); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (occupancy_1 !== 3'd0 || pipe_data_1 !== 32'h0 || pipe_valid !== 2'b00 || src_ready_1 !== 1'b1) $display("FAIL arst_clear got occ %0d d %h v %b rdy %b want 0 0 00 1", occupancy_1, pipe_data_1, pipe_valid, src_ready_1); else n_pass++;
        #1 reset = 1'b0; stall_1 = 1'b0;
        tick();
        #1;
        n_checks++; if (occupancy_1 !== 3'd0 || pipe_valid[0] !== 1'b0) $display("FAIL arst_post got occ %0d v %b want 0 0", occupancy_1, pipe_valid[0]); else n_pass++;
    endtask

    task automatic test_bypass();
        tick();
        src_data_1 = 32'hDEAD_BEEF; src_valid_1 = 1'b1;
        #1;
`ifdef INGRESS_BYPASS_EN
        n_checks++; if (pipe_valid[0] !== 1'b1 || pipe_data_1 !== 32'hDEAD_BEEF || occupancy_1 !== 3'd0) $display("FAIL bypass_same got %b/%h occ %0d want 1/deadbeef 0", pipe_valid[0], pipe_data_1, occupancy_1); else n_pass++;
`else
        n_checks++; if (pipe_valid[0] !== 1'b0) $display("FAIL nobypass_same got %b want 0", pipe_valid[0]); else n_pass++;
`endif
        tick();
        src_valid_1 = 1'b0;
        #1;
`ifdef INGRESS_BYPASS_EN
        n_checks++; if (occupancy_1 !== 3'd0 || pipe_valid[0] !== 1'b0) $display("FAIL bypass_after got occ %0d v %b want 0 0", occupancy_1, pipe_valid[0]); else n_pass++;
`else
        n_checks++; if (occupancy_1 !== 3'd1 || pipe_data_1 !== 32'hDEAD_BEEF || pipe_valid[0] !== 1'b1) $display("FAIL nobypass_after got occ %0d d %h v %b want 1 deadbeef 1", occupancy_1, pipe_data_1, pipe_valid[0]); else n_pass++;
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_stall_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_ingress_buffer

// File: doc/pipeline_ingress_buffer.md
Name: pipeline_ingress_buffer

Overview:
- Dual-lane ingress buffer directly upstream of the two-pipeline wrapper.
- Accepts one ready/valid stream per lane and absorbs work while a pipeline is stalled.
- Drives the wrapper's pipeline1_inputs/pipeline2_inputs and in_valid[1:0], consuming stall_1/stall_2 and flush_1/flush_2.
- Exists so upstream producers never lose data when the global stall asserts.

Parameters:
- DATA_W, 32, width of each lane's data word.
- DEPTH, 4, entries per lane FIFO; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy outputs (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_data_1  input  DATA_W  lane 1 producer data.
- src_valid_1  input  1  lane 1 producer valid.
- src_ready_1  output  1  lane 1 accept.
- src_data_2  input  DATA_W  lane 2 producer data.
- src_valid_2  input  1  lane 2 producer valid.
- src_ready_2  output  1  lane 2 accept.
- flush_1  input  1  discard lane 1 contents (same signal routed to pipeline 1).
- flush_2  input  1  discard lane 2 contents.
- stall_1  input  1  pipeline 1 stall.
- stall_2  input  1  pipeline 2 stall.
- pipe_data_1  output  DATA_W  to pipeline1_inputs.
- pipe_data_2  output  DATA_W  to pipeline2_inputs.
- pipe_valid  output  2  to in_valid; bit0 = lane 1, bit1 = lane 2.
- occupancy_1  output  CNT_W  lane 1 entry count.
- occupancy_2  output  CNT_W  lane 2 entry count.

Behaviour:
- Reset (async assert, sync release): pointers=0, occupancy=0, pipe_valid=0, src_ready=1, pipe_data=0.
- Lanes are fully independent; everything below applies per lane n.
- Push condition: src_valid_n && src_ready_n. Write at wr_ptr, which increments modulo DEPTH (natural wrap).
- src_ready_n = !full && !flush_n, where full = (occupancy==DEPTH). Combinational from registered state plus flush_n; no dependence on src_valid_n.
- Pop condition: pipe_valid_n, where pipe_valid_n = !empty && !stall_n && !flush_n. An entry presented while not stalled counts as consumed that cycle.
- pipe_data_n = mem[rd_ptr]; zeros when empty (no X propagation).
- Latency: data pushed in cycle t is presented at t+1 at the earliest. No bypass unless the optional feature is enabled.
- Simultaneous push+pop: occupancy unchanged, both pointers advance.
- Full: no push, since src_ready is low. A pop while full raises src_ready on the next cycle, not the same cycle.
- Empty: pipe_valid low regardless of stall.
- stall_n held high: head stays stable, pipe_valid low, FIFO fills to DEPTH, then src_ready drops.
- flush_n high: next cycle rd_ptr=wr_ptr=0 and occupancy=0. Push and pop are both suppressed during that cycle. Flush has priority over every other event.
- Reset mid-operation: all state cleared immediately; in-flight data is lost.
- Occupancy never exceeds DEPTH and never underflows. Both are assertion-checked.

Optional Feature:
- Macro INGRESS_BYPASS_EN.
- Defined: when a lane is empty, not stalled, not flushed and src_valid_n is high, src_data_n drives pipe_data_n combinationally with pipe_valid_n=1 in the same cycle. The word is not written; occupancy stays 0 (zero-latency cut-through).
- Undefined: minimum 1-cycle latency as above, no combinational path from src to pipe.

Decomposition:
- Package pipeline_ingress_pkg:
  - DATA_W=32
  - NUM_LANES=2
  - typedef lane_data_t (logic [DATA_W-1:0])
- One sub-module, ingress_lane_fifo: a single-lane FIFO with flush, stall-gated pop and optional bypass, instantiated twice.
- The top only maps ports to the two lane instances.

Test Plan:
- Reset with src_valid_1=1 → pipe_valid=2'b00, src_ready_1=src_ready_2=1, occupancy=0. After release, push 0xA5A5_0001 → pipe_data_1=0xA5A5_0001 with pipe_valid[0]=1 one cycle later.
- stall_1=1, push 0x10..0x13 → occupancy_1=4, src_ready_1=0, 5th word 0x14 not accepted. Release stall → 0x10,0x11,0x12,0x13 emitted on consecutive cycles, then src_ready_1=1.
- Continuous push/pop on lane 2 for 10 words (0x200..0x209) with stall_2=0 → occupancy_2 constant at 1, output order preserved across pointer wrap.
- Lane 1 holding 3 words, flush_1=1 for one cycle with src_valid_1=1 → that word dropped, occupancy_1=0 next cycle, pipe_valid[0]=0. Lane 2 unaffected.
- Reset asserted asynchronously mid-burst (occupancy_1=2) → outputs clear without waiting for a clock edge.
- With INGRESS_BYPASS_EN, empty lane 1 and push 0xDEAD_BEEF → pipe_data_1=0xDEAD_BEEF, pipe_valid[0]=1 in the same cycle, occupancy_1 stays 0.
